// File: rtl/io_map_pkg.sv
// Peripheral address map and 7-segment constants shared by io_bridge and seg7_scan.
package io_map_pkg;

   localparam logic [19:0] PERIPH_BASE_DEF = 20'hFFFFF;

   localparam logic [11:0] OFF_SEG   = 12'h000;
   localparam logic [11:0] OFF_TIMER = 12'h020;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;
   localparam logic [11:0] OFF_BTN   = 12'h078;

   // Active-low {dp,g,f,e,d,c,b,a}; entry n is the glyph for hex digit n, dp off.
   localparam logic [15:0][7:0] HEX_SEG = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage

// File: rtl/io_bridge_seg7_scan.sv
// 8-digit multiplexed 7-segment scan: one digit lit for SCAN_DIV cycles, outputs registered.
module seg7_scan
   import io_map_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seg_value,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cx
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] scan_cnt;
   logic [2:0]       idx;
   logic [3:0]       nibble;

   always_comb begin
      nibble = seg_value[{idx, 2'b00} +: 4];
   end

   // Outputs sample the current idx and seg_value, so a SEG write landing on a
   // digit advance shows up one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= 3'd0;
         seg_an   <= 8'hFE;
         seg_cx   <= 8'hC0;
      end else begin
         if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         seg_an <= ~(8'd1 << idx);
         seg_cx <= hex_seg(nibble);
      end
   end

endmodule

// File: rtl/io_bridge.sv
// Memory-stage address decoder routing core accesses to data RAM or LED/SW/BTN/7-seg peripherals.
// Optional free-running timer at offset 0x020 when IO_BRIDGE_TIMER_EN is defined.
module io_bridge
   import io_map_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 20000,
   parameter logic [19:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic [13:0] dram_addr,
   output logic        dram_wen,
   output logic [31:0] dram_wdata,
   input  logic [31:0] dram_rdata,
   input  logic [23:0] sw,
   input  logic [4:0]  btn,
   output logic [23:0] led,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cx
);

   logic        is_periph;
   logic [9:0]  word_off;
   logic        periph_wen;
   logic        unused_addr_bits;
   logic [31:0] periph_rdata;

   logic [31:0] seg_reg;
   logic [23:0] led_reg;
   logic [23:0] sw_s1, sw_s2;
   logic [4:0]  btn_s1, btn_s2;

   // Byte lane bits are ignored: every peripheral register is a full word.
   assign unused_addr_bits = ^cpu_addr[1:0];

   assign is_periph  = (cpu_addr[31:12] == PERIPH_BASE);
   assign word_off   = cpu_addr[11:2];
   assign periph_wen = cpu_wen & is_periph;

   assign dram_addr  = cpu_addr[15:2];
   assign dram_wen   = cpu_wen & ~is_periph;
   assign dram_wdata = cpu_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_reg <= '0;
         led_reg <= '0;
         sw_s1   <= '0;
         sw_s2   <= '0;
         btn_s1  <= '0;
         btn_s2  <= '0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
         if (periph_wen && word_off == OFF_SEG[11:2]) begin
            seg_reg <= cpu_wdata;
         end
         if (periph_wen && word_off == OFF_LED[11:2]) begin
            led_reg <= cpu_wdata[23:0];
         end
      end
   end

`ifdef IO_BRIDGE_TIMER_EN
   logic [31:0] timer_cnt;

   // A store overrides the increment on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_cnt <= '0;
      end else if (periph_wen && word_off == OFF_TIMER[11:2]) begin
         timer_cnt <= cpu_wdata;
      end else begin
         timer_cnt <= timer_cnt + 32'd1;
      end
   end
`endif

   always_comb begin
      periph_rdata = '0;
      if (word_off == OFF_SEG[11:2]) begin
         periph_rdata = seg_reg;
      end else if (word_off == OFF_LED[11:2]) begin
         periph_rdata = {8'h00, led_reg};
      end else if (word_off == OFF_SW[11:2]) begin
         periph_rdata = {8'h00, sw_s2};
      end else if (word_off == OFF_BTN[11:2]) begin
         periph_rdata = {27'h0, btn_s2};
`ifdef IO_BRIDGE_TIMER_EN
      end else if (word_off == OFF_TIMER[11:2]) begin
         periph_rdata = timer_cnt;
`endif
      end
   end

   assign cpu_rdata = is_periph ? periph_rdata : dram_rdata;
   assign led       = led_reg;

   seg7_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .seg_value (seg_reg),
      .seg_an    (seg_an),
      .seg_cx    (seg_cx)
   );

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Sits directly downstream of the pipelined miniRV CPU core's memory stage (the EX/MEM buffer outputs) and routes every data access either to the data RAM or to on-board peripherals.
- Peripherals are a LED register, switch and button sampling, and an 8-digit multiplexed 7-segment display driven by a scan sequencer.
- The core exports the full 32-bit ALU address, write enable and store data to this block. It receives its load data back combinationally in the same cycle, as the write-back select expects.

Parameters:
- SCAN_DIV, 20000, clock cycles each 7-segment digit stays lit (minimum 2).
- PERIPH_BASE, 20'hFFFFF, value of addr[31:12] that selects the peripheral region.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_addr  in  32  byte address from the core memory stage
- cpu_wen  in  1  store enable from the core
- cpu_wdata  in  32  store data from the core
- cpu_rdata  out  32  load data returned to the core (combinational)
- dram_addr  out  14  data RAM word address, equal to cpu_addr[15:2]
- dram_wen  out  1  data RAM write enable
- dram_wdata  out  32  data RAM write data, equal to cpu_wdata
- dram_rdata  in  32  data RAM read data
- sw  in  24  slide switches (asynchronous)
- btn  in  5  push buttons (asynchronous)
- led  out  24  LED drive, active-high
- seg_an  out  8  digit enables, active-low, one-hot-zero
- seg_cx  out  8  segment lines {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Clock and reset: clk is the only clock; rst is synchronous and active-high, sampled on the clk rising edge.
- Decode: is_periph = (cpu_addr[31:12] == PERIPH_BASE). Peripheral offset is cpu_addr[11:0]; the low two bits are ignored.
- Peripheral offsets:
  - 0x000 SEG: 32-bit, read/write.
  - 0x060 LED: low 24 bits, read/write.
  - 0x070 SW: read-only, {8'b0, sw_sync}.
  - 0x078 BTN: read-only, {27'b0, btn_sync}.
  - Any other offset reads 0; writes to it are ignored.
- DRAM path: dram_wen = cpu_wen & ~is_periph. A store to the peripheral region never writes RAM.
- Read mux (combinational, zero latency): cpu_rdata = is_periph ? peripheral read value : dram_rdata.
- Writes: SEG and LED registers load cpu_wdata on the clk edge where cpu_wen=1 and the offset matches. The new value is visible on cpu_rdata and led from the next cycle. Stores to read-only offsets are ignored.
- Synchronisers: sw and btn each pass through 2 flops. An input change is readable 2 edges later.
- Scan sequencer:
  - scan_cnt counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it wraps to 0 and digit index idx advances mod 8 (7 wraps to 0).
  - seg_an = ~(1<<idx).
  - seg_cx = hex decode of SEG[4*idx+3:4*idx], with dp always off. Encodings (active-low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E.
  - Both seg_an and seg_cx are registered: one cycle after idx/SEG change.
- Simultaneous SEG write and digit advance: the registered output for that edge uses the old SEG; the new value appears on the following edge.
- Reset values: led=0, SEG=0, scan_cnt=0, idx=0, sync flops=0, seg_an=8'hFE, seg_cx=8'hC0.
- Reset mid-operation: the scan restarts at digit 0 and registers clear. RAM contents are untouched, and dram_wen follows cpu_wen even during reset; the core holds cpu_wen low in reset.

Optional Feature:
- Macro: IO_BRIDGE_TIMER_EN.
- When defined:
  - 32-bit free-running counter at offset 0x020, reset 0, incrementing every cycle with wrap at 0xFFFFFFFF to 0.
  - A store to 0x020 loads cpu_wdata; the load takes precedence over increment in the same cycle.
  - A read returns the current counter value.
- When undefined: 0x020 behaves as unmapped (reads 0, writes ignored) and no counter logic exists.

Decomposition:
- Shared package io_map_pkg: PERIPH_BASE default, offset constants (OFF_SEG, OFF_TIMER, OFF_LED, OFF_SW, OFF_BTN), and the 16-entry hex-to-segment constant table.
- One sub-module seg7_scan holds scan_cnt, idx, the decode and the output registers. io_bridge holds decode, register file, synchronisers and the optional timer.

Test Plan:
- Store 0x1234_5678 to 0x0000_0010 -> dram_wen=1, dram_addr=4, dram_wdata=0x12345678; load of the same address returns dram_rdata unchanged.
- Store 0x00AB_CDEF to 0xFFFF_F060 -> dram_wen=0; led=0xABCDEF next cycle; load of 0xFFFF_F060 returns 0x00ABCDEF.
- Drive sw=0x5A5A5A at edge N -> a load of 0xFFFF_F070 returns 0 before edge N+2 and 0x005A5A5A from edge N+2 on. Drive btn=5'b10101 -> load of 0xFFFF_F078 returns 0x15.
- SCAN_DIV=4, store SEG=0x76543210:
  - seg_an steps FE, FD, FB, ..., 7F, then FE, changing every 4 cycles.
  - seg_cx shows C0, F9, A4, B0, 99, 92, 82, F8 in step.
- Load/store offset 0xFFFF_F100 -> read 0, no register or RAM change. Assert rst mid-scan at idx=5 -> next cycle seg_an=FE, seg_cx=C0, led=0.
- With IO_BRIDGE_TIMER_EN:
  - Store 0xFFFF_FFFE to 0xFFFF_F020, then read 1 and 2 cycles later -> 0xFFFFFFFF, then 0x00000000.
  - Without the macro the same read returns 0.
